// File: rtl/bin_to_bcd_pkg.sv
// -----------------------------------------------------------------------------
// g : shared types for the binary-to-BCD conversion path.
//   BCD_DIGITS : default digit count of a packed BCD word
//   bcd_t      : packed BCD word, most significant digit in the top nibble
// -----------------------------------------------------------------------------
package g;

  localparam int unsigned BCD_DIGITS = 3;

  typedef logic [4*BCD_DIGITS-1:0] bcd_t;

endpackage

// File: rtl/bin_to_bcd_dabble_digit.sv
// -----------------------------------------------------------------------------
// dabble_digit : combinational double-dabble correction for one BCD nibble.
//   digit_in  : current nibble value
//   digit_out : digit_in + 3 when digit_in >= 5, otherwise digit_in unchanged
// -----------------------------------------------------------------------------
module dabble_digit (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  always_comb begin
    digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;
  end

endmodule

// File: rtl/bin_to_bcd.sv
// -----------------------------------------------------------------------------
// bin_to_bcd : sequential double-dabble binary to packed-BCD converter.
//   sys_clk     : clock, rising edge
//   sys_rst     : asynchronous active-high reset
//   bin_in_en   : one-cycle strobe, bin_in valid
//   bin_in      : unsigned binary value (BIN_W bits)
//   bcd_out_en  : one-cycle pulse, bcd_out holds a new result
//   bcd_out     : packed BCD result (4*DIGITS bits), held between results
//   busy_out    : high while a conversion is in progress
//   overrun_out : one-cycle pulse when a strobe is dropped
// A one-deep pending register absorbs a single strobe that arrives while busy.
// -----------------------------------------------------------------------------
module bin_to_bcd
  import g::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  bin_in_en,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  bcd_out_en,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  busy_out,
  output logic                  overrun_out
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BIN_W + BCD_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t             state, state_nxt;
  logic [SR_W-1:0]    sr, sr_nxt;
  logic [SR_W-1:0]    sr_adj, sr_step;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [BIN_W-1:0]   pend, pend_nxt;
  logic               pend_vld, pend_vld_nxt;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_out_nxt;
  logic               bcd_out_en_nxt;
  logic               overrun_nxt;
  logic               last_iter;

  // Per-digit +3 correction applied to the BCD field before each shift.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    dabble_digit u_dabble_digit (
      .digit_in  (sr[BIN_W + 4*i +: 4]),
      .digit_out (bcd_adj[4*i +: 4])
    );
  end

  always_comb begin
    sr_adj    = {bcd_adj, sr[BIN_W-1:0]};
    sr_step   = {sr_adj[SR_W-2:0], 1'b0};
    last_iter = (cnt == CNT_W'(BIN_W - 1));
  end

  assign busy_out = (state == S_SHIFT);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    sr_nxt         = sr;
    cnt_nxt        = cnt;
    pend_nxt       = pend;
    pend_vld_nxt   = pend_vld;
    bcd_out_nxt    = bcd_out;
    bcd_out_en_nxt = 1'b0;
    overrun_nxt    = 1'b0;

    case (state)
      S_IDLE: begin
        if (bin_in_en) begin
          sr_nxt    = {{BCD_W{1'b0}}, bin_in};
          cnt_nxt   = '0;
          state_nxt = S_SHIFT;
        end
      end

      S_SHIFT: begin
        sr_nxt  = sr_step;
        cnt_nxt = cnt + 1'b1;
        if (last_iter) begin
          bcd_out_nxt    = sr_step[SR_W-1 -: BCD_W];
          bcd_out_en_nxt = 1'b1;
          cnt_nxt        = '0;
          // Restart back-to-back: pending wins over a coincident strobe,
          // which then refills pending instead of being dropped.
          if (pend_vld) begin
            sr_nxt = {{BCD_W{1'b0}}, pend};
            if (bin_in_en) begin
              pend_nxt = bin_in;
            end else begin
              pend_vld_nxt = 1'b0;
            end
          end else if (bin_in_en) begin
            sr_nxt = {{BCD_W{1'b0}}, bin_in};
          end else begin
            state_nxt = S_IDLE;
          end
        end else if (bin_in_en) begin
          if (!pend_vld) begin
            pend_nxt     = bin_in;
            pend_vld_nxt = 1'b1;
          end else begin
            overrun_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sr          <= '0;
      cnt         <= '0;
      pend        <= '0;
      pend_vld    <= 1'b0;
      bcd_out     <= '0;
      bcd_out_en  <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      sr          <= sr_nxt;
      cnt         <= cnt_nxt;
      pend        <= pend_nxt;
      pend_vld    <= pend_vld_nxt;
      bcd_out     <= bcd_out_nxt;
      bcd_out_en  <= bcd_out_en_nxt;
      overrun_out <= overrun_nxt;
    end
  end

endmodule

// File: doc/bin_to_bcd.md
BIN_TO_BCD -- requirements
Module: bin_to_bcd

Interface
REQ-001 SHALL have parameter BIN_W, default 8, which is the binary input width and the number of shift iterations.
REQ-002 SHALL have parameter DIGITS, default 3, which is the number of BCD output digits; 4*DIGITS is the bcd_out width.
REQ-003 SHALL have sys_clk  input  1  as its single clock, with all logic on the rising edge.
REQ-004 SHALL have sys_rst  input  1  as its reset, which is asynchronous and active-high.
REQ-005 SHALL have bin_in_en  input  1  as a one-cycle strobe indicating that bin_in is valid.
REQ-006 SHALL have bin_in  input  BIN_W  as the unsigned binary value to convert.
REQ-007 SHALL have bcd_out_en  output  1  as a one-cycle pulse indicating that bcd_out is valid, feeding the display formatter's bcd_in_en.
REQ-008 SHALL have bcd_out  output  4*DIGITS (g::bcd_t at defaults)  as the packed BCD result, most significant digit in the top nibble.
REQ-009 SHALL have busy_out  output  1  which is high while a conversion is in progress.
REQ-010 SHALL have overrun_out  output  1  as a one-cycle pulse when an input is dropped.

Function
REQ-011 SHALL implement the sequential double-dabble algorithm with a shift register of width BIN_W+4*DIGITS and BCD field cleared at start.
REQ-012 SHALL have FSM states S_IDLE and S_SHIFT, plus an iteration counter of width clog2(BIN_W+1).
REQ-013 SHALL, in S_IDLE with bin_in_en high: load bin_in, clear the counter, enter S_SHIFT, and raise busy_out on that edge.
REQ-014 SHALL, on each S_SHIFT edge: add 3 to every BCD nibble whose value is >=5, then shift left 1, then increment the counter.
REQ-015 SHALL, on the edge completing iteration BIN_W: register bcd_out, pulse bcd_out_en high for exactly one cycle, and leave S_SHIFT.
REQ-016 SHALL make latency exactly BIN_W edges from the capturing edge to the edge raising bcd_out_en, i.e. 8 at default.
REQ-017 SHALL hold bcd_out stable between results; bcd_out changes only on edges where bcd_out_en rises.
REQ-018 SHALL provide a one-deep pending register; bin_in_en while busy with pending empty SHALL store bin_in in the pending register.
REQ-019 SHALL, on bin_in_en while busy with pending full, drop the new value, keep pending unchanged, and pulse overrun_out for one cycle.
REQ-020 SHALL, at the completion edge with pending full, load pending into the shift register and stay in S_SHIFT with busy_out high and pending cleared.
REQ-021 SHALL, at the completion edge with pending empty and bin_in_en high, start a conversion from bin_in directly, so busy_out stays high.
REQ-022 SHALL, at the completion edge with pending full and bin_in_en high, start from pending and store bin_in as the new pending, with no overrun.
REQ-023 SHALL, at the completion edge with no pending data and no bin_in_en, return to S_IDLE with busy_out low on that edge.
REQ-024 SHALL truncate silently if the input exceeds the DIGITS capacity (10^DIGITS-1); at defaults 255 always fits.

Reset
REQ-025 SHALL, while sys_rst is high, force state S_IDLE and set bcd_out=0, bcd_out_en=0, busy_out=0, overrun_out=0, pending empty, and counter=0.
REQ-026 SHALL abandon any conversion in progress when reset asserts mid-conversion, never emit its result, and discard pending data.
REQ-027 SHALL accept the first bin_in_en on the first rising edge after sys_rst deasserts.

Structure
REQ-028 SHALL take bcd_t from shared package g; state_t and the iteration counter width SHALL be local to the module.
REQ-029 SHALL instantiate a combinational sub-module dabble_digit (4-bit in, 4-bit out, +3 if >=5) once per digit through a generate loop.

Verification
REQ-030 Bench SHALL cover: bin_in=255 with a single strobe -> bcd_out=12'h255 with bcd_out_en pulsing 8 edges after capture; busy_out high for 8 cycles.
REQ-031 Bench SHALL cover: bin_in=0 -> bcd_out=12'h000 with bcd_out_en still pulsing once; bin_in=128 -> 12'h128; exhaustive 0..255 compared against a reference model.
REQ-032 Bench SHALL cover: strobes 42 then 7 two cycles apart -> 12'h042, then 12'h007 exactly 8 edges later, with busy_out continuously high and no overrun.
REQ-033 Bench SHALL cover: strobes 1, 2, 3 on consecutive cycles -> results 001 and 002 only, with overrun_out pulsing once on the third strobe.
REQ-034 Bench SHALL cover: sys_rst pulsed at iteration 4 of converting 200 -> no bcd_out_en, all outputs zero; a subsequent strobe of 99 yields 12'h099.
REQ-035 Bench SHALL cover: bin_in_en coincident with the completion edge and pending empty -> the new result follows 8 edges later with no idle gap.
